udp_port_dispatch: RTL and testbench
====================================

Name: udp_port_dispatch

Overview:
- Parametrised successor to the fixed single-path UDP receive chain.
- Takes the reassembled UDP payload stream plus its destination port and routes each datagram to one of NUM_CH output channels using a runtime port table.
- Unmatched datagrams are either dropped or sent to a default channel; per-channel frame and drop statistics are kept.
- Sits between udp_rcv and the per-application consumers (udp_forward, command decoders).

Parameters:
- DATA_W, 8: beat width in bits; a multiple of 8.
- NUM_CH, 4: number of output channels, 2..8.
- UNMATCHED_MODE, 0: 0 = drop unmatched datagrams; 1 = route them to DEFAULT_CH.
- DEFAULT_CH, 0: channel that receives unmatched datagrams when UNMATCHED_MODE=1.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- port_table_in  in  NUM_CH*16  UDP port for channel k at bits [16k+15:16k].
- ch_enable_in  in  NUM_CH  per-channel enable; a disabled channel never matches.
- s_tdata  in  DATA_W  input payload.
- s_tkeep  in  DATA_W/8  byte valid mask.
- s_tvalid  in  1  input valid.
- s_tlast  in  1  last beat of the datagram.
- s_dest_port  in  16  destination port; valid on the first beat of a datagram.
- s_tready  out  1  input ready.
- m_tdata  out  DATA_W  shared output data bus.
- m_tkeep  out  DATA_W/8  shared output byte mask.
- m_tvalid  out  NUM_CH  one-hot output valid.
- m_tfirst  out  1  first beat of the datagram.
- m_tlast  out  1  last beat of the datagram.
- m_tready  in  NUM_CH  per-channel ready.
- frame_cnt_out  out  NUM_CH*CNT_W  datagrams delivered per channel; saturating.
- drop_cnt_out  out  CNT_W  datagrams dropped; saturating.
- busy_out  out  1  high whenever the FSM is not in IDLE or the skid buffer holds data.

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE, skid buffer emptied, all counters 0, s_tready=0, m_tvalid=0, m_tfirst=0, m_tlast=0, busy_out=0.
- FSM states: IDLE, FWD, DROP.
- IDLE:
  - s_tready=0.
  - When s_tvalid=1 and the skid buffer is empty, evaluate the match and register it in the same cycle:
    - match = lowest k with ch_enable_in[k]=1 and port_table_in[k]=s_dest_port.
    - If matched: sel<=k, go to FWD.
    - If unmatched and UNMATCHED_MODE=1: sel<=DEFAULT_CH, go to FWD.
    - Otherwise go to DROP.
  - The first beat is not consumed in IDLE. Decision latency is 1 cycle.
- FWD:
  - s_tready = skid buffer ready.
  - Each accepted beat enters the 2-entry skid buffer (sub-module).
  - m_tvalid[k] = skid valid and (sel==k); skid pop = m_tready[sel].
  - m_tfirst=1 on the first output beat of each datagram.
  - Accepting s_tlast returns the FSM to IDLE.
  - sel changes only in IDLE with the skid buffer empty, so no beat is ever misrouted.
- DROP:
  - s_tready=1; beats are discarded and s_tkeep is ignored.
  - Accepting s_tlast increments drop_cnt and returns to IDLE.
- Table latching: port_table_in and ch_enable_in are sampled only at the IDLE decision. Changes mid-datagram do not affect the current datagram.
- Single-beat datagram (s_tlast on the first beat): handled normally. m_tfirst and m_tlast are asserted together.
- frame_cnt[k] increments when the output handshake with m_tlast=1 completes on channel k.
- Both counters saturate at all-ones; no wrap.
- Throughput: 1 beat/clk in FWD with continuous m_tready. Input-to-output latency is 1 cycle. The bubble between datagrams is 1 cycle for the decision plus the skid drain.
- Backpressure: m_tready low for any number of cycles loses no data. The skid buffer fills to 2 entries, then s_tready drops.
- Reset mid-datagram: the partial datagram is abandoned with no counter update. The next valid beat is treated as a first beat.

Decomposition:
- Shared package udp_pkg:
  - state encoding (IDLE/FWD/DROP);
  - UDP port width constant (16);
  - UNMATCHED_MODE encodings (DROP_UNMATCHED=0, ROUTE_DEFAULT=1).
- Sub-module axis_skid_buf: 2-entry register slice carrying {tdata, tkeep, tfirst, tlast}, on clk and reset.
- Match priority encoder and counters remain inline.

Test Plan:
- Table {5000,5001,5002,5003}, all enabled; 4-beat datagram to port 5002 with m_tready all high -> only m_tvalid[2] toggles; beats delivered in order with m_tfirst on beat 0 and m_tlast on beat 3; frame_cnt[2]=1.
- Port 6000, UNMATCHED_MODE=0 -> s_tready=1 for 4 beats, no m_tvalid, drop_cnt=1. Rerun with UNMATCHED_MODE=1, DEFAULT_CH=0 -> datagram appears on channel 0.
- Ports 5001 on ch1 and ch3, ch1 disabled -> datagram goes to ch3. With ch1 enabled -> datagram goes to ch1.
- m_tready[1] low for 10 cycles during an 8-beat datagram -> s_tready low after 2 buffered beats; all 8 beats received intact; no duplicates.
- Back-to-back single-beat datagrams to ports 5000 then 5003 -> ch0 then ch3, each with m_tfirst=m_tlast=1; frame_cnt[0]=frame_cnt[3]=1.
- Reset asserted at beat 2 of a 6-beat datagram -> outputs immediately low and counters 0. A new datagram after reset routes correctly.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared definitions for the UDP receive path: dispatcher states, port width and
// the unmatched-datagram policy encodings.
package udp_pkg;

  localparam int unsigned UDP_PORT_W     = 16;
  localparam int unsigned DROP_UNMATCHED = 0;
  localparam int unsigned ROUTE_DEFAULT  = 1;

  typedef enum logic [1:0] {
    StIdle,
    StFwd,
    StDrop
  } disp_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register slice for a stream beat. The input is ready while fewer than
// two beats are held, so a stalled consumer never loses data.
module axis_skid_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             w_push;
  logic             w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head;
  assign w_push  = i_valid & o_ready;
  assign w_pop   = o_valid & i_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 2'd0;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_head <= i_data;
          else                 r_tail <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head  <= r_tail;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Count stays put; with one entry the new beat replaces the head.
          if (r_count == 2'd1) begin
            r_head <= i_data;
          end else begin
            r_head <= r_tail;
            r_tail <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/udp_port_dispatch.sv
// Routes each UDP datagram to one of NUM_CH channels by destination port, dropping
// or defaulting unmatched ones, and keeps per-channel delivery and drop counters.
module udp_port_dispatch
  import udp_pkg::*;
#(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned UNMATCHED_MODE = 0,
  parameter int unsigned DEFAULT_CH     = 0,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH*UDP_PORT_W-1:0] port_table_in,
  input  logic [NUM_CH-1:0]            ch_enable_in,
  input  logic [DATA_W-1:0]            s_tdata,
  input  logic [DATA_W/8-1:0]          s_tkeep,
  input  logic                         s_tvalid,
  input  logic                         s_tlast,
  input  logic [UDP_PORT_W-1:0]        s_dest_port,
  output logic                         s_tready,
  output logic [DATA_W-1:0]            m_tdata,
  output logic [DATA_W/8-1:0]          m_tkeep,
  output logic [NUM_CH-1:0]            m_tvalid,
  output logic                         m_tfirst,
  output logic                         m_tlast,
  input  logic [NUM_CH-1:0]            m_tready,
  output logic [NUM_CH*CNT_W-1:0]      frame_cnt_out,
  output logic [CNT_W-1:0]             drop_cnt_out,
  output logic                         busy_out
);

  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PKT_W = DATA_W + DATA_W / 8 + 2;

  disp_state_e                   r_state;
  logic [SEL_W-1:0]              r_sel;
  logic                          r_first_pend;
  logic [CNT_W-1:0]              r_drop_cnt;
  logic [NUM_CH-1:0][CNT_W-1:0]  r_frame_cnt;

  logic             w_hit;
  logic [SEL_W-1:0] w_idx;
  logic             w_accept;
  logic             w_skid_in_ready;
  logic             w_skid_out_valid;
  logic             w_skid_pop;
  logic             w_out_first;
  logic             w_out_last;
  logic             w_deliver;
  logic [PKT_W-1:0] w_in_pkt;
  logic [PKT_W-1:0] w_out_pkt;

  // Lowest enabled channel whose port matches wins.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (ch_enable_in[k] && (port_table_in[k*UDP_PORT_W +: UDP_PORT_W] == s_dest_port)) begin
        w_hit = 1'b1;
        w_idx = SEL_W'(k);
      end
    end
  end

  assign s_tready = ((r_state == StFwd) && w_skid_in_ready) || (r_state == StDrop);
  assign w_accept = s_tvalid & s_tready;
  assign w_in_pkt = {s_tdata, s_tkeep, r_first_pend, s_tlast};

  axis_skid_buf #(
    .WIDTH(PKT_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_valid (s_tvalid && (r_state == StFwd)),
    .o_ready (w_skid_in_ready),
    .i_data  (w_in_pkt),
    .o_valid (w_skid_out_valid),
    .i_ready (w_skid_pop),
    .o_data  (w_out_pkt)
  );

  assign {m_tdata, m_tkeep, w_out_first, w_out_last} = w_out_pkt;
  assign w_skid_pop = m_tready[r_sel];
  assign m_tfirst   = w_skid_out_valid & w_out_first;
  assign m_tlast    = w_skid_out_valid & w_out_last;
  assign w_deliver  = w_skid_out_valid & w_skid_pop & w_out_last;
  assign busy_out   = (r_state != StIdle) || w_skid_out_valid;

  always_comb begin
    m_tvalid = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      m_tvalid[k] = w_skid_out_valid && (r_sel == SEL_W'(k));
    end
  end

  // The decision waits for an empty skid so r_sel never changes under a queued beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= StIdle;
      r_sel        <= '0;
      r_first_pend <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (s_tvalid && !w_skid_out_valid) begin
            r_first_pend <= 1'b1;
            if (w_hit) begin
              r_sel   <= w_idx;
              r_state <= StFwd;
            end else if (UNMATCHED_MODE == ROUTE_DEFAULT) begin
              r_sel   <= SEL_W'(DEFAULT_CH);
              r_state <= StFwd;
            end else begin
              r_state <= StDrop;
            end
          end
        end
        StFwd: begin
          if (w_accept) begin
            r_first_pend <= 1'b0;
            if (s_tlast) r_state <= StIdle;
          end
        end
        StDrop: begin
          if (w_accept && s_tlast) begin
            if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_cnt <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_deliver && (r_sel == SEL_W'(k)) && (r_frame_cnt[k] != '1)) begin
          r_frame_cnt[k] <= r_frame_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  assign frame_cnt_out = r_frame_cnt;
  assign drop_cnt_out  = r_drop_cnt;

endmodule

// File: tb/tb_udp_port_dispatch.sv
// Directed bench for udp_port_dispatch: a drop-mode instance and a default-route
// instance with narrow counters share one stimulus stream.
module tb_udp_port_dispatch;

  typedef struct {
    int         ch;
    logic [7:0] data;
    logic       keep;
    logic       first;
    logic       last;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [63:0] port_table;
  logic [3:0]  ch_enable;
  logic [7:0]  s_tdata;
  logic        s_tkeep;
  logic        s_tvalid;
  logic        s_tlast;
  logic [15:0] s_dest_port;
  logic [3:0]  m_tready;

  logic        s_tready, m_tfirst, m_tlast, busy;
  logic [7:0]  m_tdata;
  logic        m_tkeep;
  logic [3:0]  m_tvalid;
  logic [63:0] frame_cnt;
  logic [15:0] drop_cnt;

  logic        d_s_tready, d_m_tfirst, d_m_tlast, d_busy;
  logic [7:0]  d_m_tdata;
  logic        d_m_tkeep;
  logic [3:0]  d_m_tvalid;
  logic [7:0]  d_frame_cnt;
  logic [1:0]  d_drop_cnt;

  beat_t q[$];
  beat_t qd[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    multi_hot = 0;
  int    cyc;

  always #5 clk = ~clk;

  udp_port_dispatch #(
    .DATA_W(8), .NUM_CH(4), .UNMATCHED_MODE(0), .DEFAULT_CH(0), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .port_table_in(port_table), .ch_enable_in(ch_enable),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_dest_port(s_dest_port), .s_tready(s_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tvalid(m_tvalid), .m_tfirst(m_tfirst), .m_tlast(m_tlast), .m_tready(m_tready),
    .frame_cnt_out(frame_cnt), .drop_cnt_out(drop_cnt), .busy_out(busy)
  );

  udp_port_dispatch #(
    .DATA_W(8), .NUM_CH(4), .UNMATCHED_MODE(1), .DEFAULT_CH(0), .CNT_W(2)
  ) dut_def (
    .clk(clk), .reset(reset), .port_table_in(port_table), .ch_enable_in(ch_enable),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_dest_port(s_dest_port), .s_tready(d_s_tready), .m_tdata(d_m_tdata),
    .m_tkeep(d_m_tkeep), .m_tvalid(d_m_tvalid), .m_tfirst(d_m_tfirst), .m_tlast(d_m_tlast),
    .m_tready(m_tready), .frame_cnt_out(d_frame_cnt), .drop_cnt_out(d_drop_cnt),
    .busy_out(d_busy)
  );

  always @(negedge clk) begin
    if ($countones(m_tvalid) > 1) multi_hot++;
    for (int k = 0; k < 4; k++) begin
      if (m_tvalid[k] && m_tready[k])
        q.push_back('{ch: k, data: m_tdata, keep: m_tkeep, first: m_tfirst, last: m_tlast});
      if (d_m_tvalid[k] && m_tready[k])
        qd.push_back('{ch: k, data: d_m_tdata, keep: d_m_tkeep, first: d_m_tfirst,
                       last: d_m_tlast});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required finish before 500us");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] port, input int n, input logic [7:0] base,
                      input bit with_last, output int cycles);
    int i = 0;
    int guard = 0;
    s_dest_port = port;
    while (i < n && guard < 200) begin
      s_tvalid = 1'b1;
      s_tdata  = base + 8'(i);
      s_tkeep  = 1'b1;
      s_tlast  = with_last && (i == n - 1);
      @(negedge clk);
      if (s_tready) i++;
      @(posedge clk);
      #1;
      guard++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    cycles   = guard;
    chk("send_done", 64'(i), 64'(n));
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((busy || d_busy) && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("drain_in_time", 64'(g < 100), 64'd1);
  endtask

  task automatic check_beats(input string tag, input beat_t bq[$], input int ch, input int n,
                             input logic [7:0] base);
    chk($sformatf("%s_count", tag), 64'(bq.size()), 64'(n));
    for (int i = 0; i < bq.size() && i < n; i++) begin
      chk($sformatf("%s_b%0d_ch", tag, i), 64'(bq[i].ch), 64'(ch));
      chk($sformatf("%s_b%0d_data", tag, i), 64'(bq[i].data), 64'(base + 8'(i)));
      chk($sformatf("%s_b%0d_keep", tag, i), 64'(bq[i].keep), 64'd1);
      chk($sformatf("%s_b%0d_first", tag, i), 64'(bq[i].first), 64'(i == 0));
      chk($sformatf("%s_b%0d_last", tag, i), 64'(bq[i].last), 64'(i == n - 1));
    end
  endtask

  initial begin
    port_table  = {16'd5003, 16'd5002, 16'd5001, 16'd5000};
    ch_enable   = 4'hF;
    s_tdata     = '0;
    s_tkeep     = 1'b1;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    s_dest_port = '0;
    m_tready    = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tfirst", 64'(m_tfirst), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_frame_cnt", frame_cnt, 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;

    // Matched 4-beat datagram to ch2; 1 decision cycle + 4 beats.
    send(16'd5002, 4, 8'h10, 1'b1, cyc);
    chk("t1_cycles", 64'(cyc), 64'd5);
    wait_idle();
    check_beats("t1", q, 2, 4, 8'h10);
    chk("t1_frame2", 64'(frame_cnt[47:32]), 64'd1);
    chk("t1_frame0", 64'(frame_cnt[15:0]), 64'd0);
    q.delete();
    qd.delete();

    // Unmatched port: dropped by dut, routed to ch0 by dut_def.
    send(16'd6000, 4, 8'h20, 1'b1, cyc);
    chk("t2_cycles", 64'(cyc), 64'd5);
    wait_idle();
    chk("t2_no_output", 64'(q.size()), 64'd0);
    chk("t2_drop_cnt", 64'(drop_cnt), 64'd1);
    check_beats("t2_def", qd, 0, 4, 8'h20);
    chk("t2_def_drop", 64'(d_drop_cnt), 64'd0);
    chk("t2_def_frame0", 64'(d_frame_cnt[1:0]), 64'd1);
    q.delete();
    qd.delete();

    // Duplicate port on ch1/ch3 with ch1 disabled, then enabled.
    port_table[63:48] = 16'd5001;
    ch_enable = 4'b1101;
    send(16'd5001, 3, 8'h30, 1'b1, cyc);
    wait_idle();
    check_beats("t3a", q, 3, 3, 8'h30);
    chk("t3a_frame3", 64'(frame_cnt[63:48]), 64'd1);
    q.delete();
    ch_enable = 4'hF;
    send(16'd5001, 2, 8'h40, 1'b1, cyc);
    wait_idle();
    check_beats("t3b", q, 1, 2, 8'h40);
    chk("t3b_frame1", 64'(frame_cnt[31:16]), 64'd1);
    q.delete();
    qd.delete();
    port_table[63:48] = 16'd5003;

    // Stall ch1 for 10 cycles mid-datagram; table edits must not disturb it.
    fork
      send(16'd5001, 8, 8'h50, 1'b1, cyc);
      begin
        repeat (3) @(posedge clk);
        #2;
        m_tready[1] = 1'b0;
        ch_enable = 4'h0;
        repeat (10) @(posedge clk);
        #2;
        chk("t4_s_tready_low", 64'(s_tready), 64'd0);
        chk("t4_busy", 64'(busy), 64'd1);
        m_tready[1] = 1'b1;
        ch_enable = 4'hF;
      end
    join
    wait_idle();
    check_beats("t4", q, 1, 8, 8'h50);
    chk("t4_frame1", 64'(frame_cnt[31:16]), 64'd2);
    chk("t4_one_hot", 64'(multi_hot), 64'd0);
    q.delete();
    qd.delete();

    // Back-to-back single-beat datagrams.
    send(16'd5000, 1, 8'h60, 1'b1, cyc);
    send(16'd5003, 1, 8'h61, 1'b1, cyc);
    wait_idle();
    chk("t5_count", 64'(q.size()), 64'd2);
    if (q.size() == 2) begin
      chk("t5_b0", {32'(q[0].ch), 8'(q[0].data), 6'd0, q[0].first, q[0].last},
          {32'd0, 8'h60, 6'd0, 1'b1, 1'b1});
      chk("t5_b1", {32'(q[1].ch), 8'(q[1].data), 6'd0, q[1].first, q[1].last},
          {32'd3, 8'h61, 6'd0, 1'b1, 1'b1});
    end
    chk("t5_frame0", 64'(frame_cnt[15:0]), 64'd1);
    chk("t5_frame3", 64'(frame_cnt[63:48]), 64'd2);
    q.delete();
    qd.delete();

    // 2-bit counters in dut_def saturate at 3.
    send(16'd5001, 1, 8'h90, 1'b1, cyc);
    wait_idle();
    chk("t6_def_frame1_3", 64'(d_frame_cnt[3:2]), 64'd3);
    send(16'd5001, 1, 8'h91, 1'b1, cyc);
    wait_idle();
    chk("t6_def_frame1_sat", 64'(d_frame_cnt[3:2]), 64'd3);
    chk("t6_frame1", 64'(frame_cnt[31:16]), 64'd4);

    // Reset at beat 2 of a 6-beat datagram.
    send(16'd5002, 2, 8'h70, 1'b0, cyc);
    s_tvalid = 1'b1;
    s_tdata  = 8'h72;
    reset    = 1'b0;
    #1;
    chk("t7_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("t7_s_tready", 64'(s_tready), 64'd0);
    chk("t7_busy", 64'(busy), 64'd0);
    chk("t7_first_last", {62'd0, m_tfirst, m_tlast}, 64'd0);
    chk("t7_frame_cnt", frame_cnt, 64'd0);
    chk("t7_drop_cnt", 64'(drop_cnt), 64'd0);
    s_tvalid = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    qd.delete();
    send(16'd5003, 2, 8'h80, 1'b1, cyc);
    chk("t7_cycles", 64'(cyc), 64'd3);
    wait_idle();
    check_beats("t7", q, 3, 2, 8'h80);
    chk("t7_frame3", 64'(frame_cnt[63:48]), 64'd1);
    chk("t7_frame2", 64'(frame_cnt[47:32]), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
